// File: rtl/reservation_station_if.sv
// Dispatch/broadcast/issue bundle between the issue stage, the two CDBs
// and the ALU on one side and the reservation station on the other.
//
// Handshake semantics:
//   issue_sgn is a one-cycle valid; the station accepts it at the rising
//   edge when rs_full=0 (rs_full is the inverted ready) and rdy=1. A
//   dispatch presented while rs_full=1 is dropped, not stalled.
//   cdb_*_sgn and alu_sgn are valid-only pulses with no back-pressure:
//   the consumer must take them in the cycle they are high.
interface reservation_station_if #(
    parameter int RS_SIZE = 8,
    parameter int ROB_W   = 4
);
    logic              issue_sgn;
    logic [5:0]        issue_opcode;
    logic [31:0]       issue_vj;
    logic [31:0]       issue_vk;
    logic [31:0]       issue_imm;
    logic [31:0]       issue_pc;
    logic              issue_qj_busy;
    logic              issue_qk_busy;
    logic [ROB_W-1:0]  issue_qj;
    logic [ROB_W-1:0]  issue_qk;
    logic [ROB_W-1:0]  issue_rob;

    logic              cdb_alu_sgn;
    logic [ROB_W-1:0]  cdb_alu_rob;
    logic [31:0]       cdb_alu_val;
    logic              cdb_lsb_sgn;
    logic [ROB_W-1:0]  cdb_lsb_rob;
    logic [31:0]       cdb_lsb_val;

    logic              rob_clear;

    logic              rs_full;
    logic              alu_sgn;
    logic [5:0]        alu_opcode;
    logic [31:0]       alu_lhs;
    logic [31:0]       alu_rhs;
    logic [31:0]       alu_imm;
    logic [31:0]       alu_pc;
    logic [ROB_W-1:0]  alu_rob;

    // Registered busy vector, exposed for observation only.
    logic [RS_SIZE-1:0] dbg_busy;

    modport master (
        output issue_sgn, issue_opcode, issue_vj, issue_vk, issue_imm, issue_pc,
               issue_qj_busy, issue_qk_busy, issue_qj, issue_qk, issue_rob,
               cdb_alu_sgn, cdb_alu_rob, cdb_alu_val,
               cdb_lsb_sgn, cdb_lsb_rob, cdb_lsb_val, rob_clear,
        input  rs_full, alu_sgn, alu_opcode, alu_lhs, alu_rhs, alu_imm, alu_pc,
               alu_rob, dbg_busy
    );

    modport slave (
        input  issue_sgn, issue_opcode, issue_vj, issue_vk, issue_imm, issue_pc,
               issue_qj_busy, issue_qk_busy, issue_qj, issue_qk, issue_rob,
               cdb_alu_sgn, cdb_alu_rob, cdb_alu_val,
               cdb_lsb_sgn, cdb_lsb_rob, cdb_lsb_val, rob_clear,
        output rs_full, alu_sgn, alu_opcode, alu_lhs, alu_rhs, alu_imm, alu_pc,
               alu_rob, dbg_busy
    );
endinterface

// File: rtl/reservation_station.sv
// ALU reservation station: holds dispatched instructions until both
// operands are available (captured from either CDB), then issues the
// lowest-index ready entry to the ALU, one per cycle.
module reservation_station #(
    parameter int RS_SIZE = 8,
    parameter int ROB_W   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    reservation_station_if.slave bus
);
    localparam int IDX_W = $clog2(RS_SIZE);

    typedef struct packed {
        logic [5:0]       opcode;
        logic [31:0]      vj;
        logic [31:0]      vk;
        logic             qj_busy;
        logic [ROB_W-1:0] qj;
        logic             qk_busy;
        logic [ROB_W-1:0] qk;
        logic [31:0]      imm;
        logic [31:0]      pc;
        logic [ROB_W-1:0] rob;
    } entry_t;

    typedef struct packed {
        logic        pend;
        logic [31:0] val;
    } opnd_t;

    // Local copies of the broadcast buses so the snoop helper stays simple.
    logic             cdb_alu_sgn;
    logic [ROB_W-1:0] cdb_alu_rob;
    logic [31:0]      cdb_alu_val;
    logic             cdb_lsb_sgn;
    logic [ROB_W-1:0] cdb_lsb_rob;
    logic [31:0]      cdb_lsb_val;

    assign cdb_alu_sgn = bus.cdb_alu_sgn;
    assign cdb_alu_rob = bus.cdb_alu_rob;
    assign cdb_alu_val = bus.cdb_alu_val;
    assign cdb_lsb_sgn = bus.cdb_lsb_sgn;
    assign cdb_lsb_rob = bus.cdb_lsb_rob;
    assign cdb_lsb_val = bus.cdb_lsb_val;

    // A pending operand picks up the value from whichever CDB carries its tag.
    function automatic opnd_t snoop(input logic pend, input logic [ROB_W-1:0] tag,
                                    input logic [31:0] val);
        opnd_t r;
        r.pend = pend;
        r.val  = val;
        if (pend) begin
            if (cdb_alu_sgn && (cdb_alu_rob == tag)) begin
                r.pend = 1'b0;
                r.val  = cdb_alu_val;
            end else if (cdb_lsb_sgn && (cdb_lsb_rob == tag)) begin
                r.pend = 1'b0;
                r.val  = cdb_lsb_val;
            end
        end
        return r;
    endfunction

    logic [RS_SIZE-1:0] busy_q, busy_d;
    entry_t             ent_q [RS_SIZE];
    entry_t             ent_d [RS_SIZE];

    logic             alu_sgn_q,    alu_sgn_d;
    logic [5:0]       alu_opcode_q, alu_opcode_d;
    logic [31:0]      alu_lhs_q,    alu_lhs_d;
    logic [31:0]      alu_rhs_q,    alu_rhs_d;
    logic [31:0]      alu_imm_q,    alu_imm_d;
    logic [31:0]      alu_pc_q,     alu_pc_d;
    logic [ROB_W-1:0] alu_rob_q,    alu_rob_d;

    logic [RS_SIZE-1:0] ready;
    logic               rs_full;
    logic               sel_valid;
    logic [IDX_W-1:0]   sel_idx;
    logic               free_valid;
    logic [IDX_W-1:0]   free_idx;
    logic               disp;
    entry_t             new_ent;
    opnd_t              new_j, new_k;

    assign rs_full = &busy_q;
    assign disp    = rdy && bus.issue_sgn && !rs_full && free_valid;

    // Ready and free vectors come from registered state only.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            ready[i] = busy_q[i] && !ent_q[i].qj_busy && !ent_q[i].qk_busy;
        end
    end

    // Lowest-index ready entry (issue) and lowest-index free entry (dispatch).
    always_comb begin
        sel_valid  = 1'b0;
        sel_idx    = '0;
        free_valid = 1'b0;
        free_idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (ready[i]) begin
                sel_valid = 1'b1;
                sel_idx   = IDX_W'(i);
            end
            if (!busy_q[i]) begin
                free_valid = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // Incoming entry, with same-cycle CDB bypass on its pending operands.
    always_comb begin
        new_j           = snoop(bus.issue_qj_busy, bus.issue_qj, bus.issue_vj);
        new_k           = snoop(bus.issue_qk_busy, bus.issue_qk, bus.issue_vk);
        new_ent.opcode  = bus.issue_opcode;
        new_ent.vj      = new_j.val;
        new_ent.qj_busy = new_j.pend;
        new_ent.qj      = bus.issue_qj;
        new_ent.vk      = new_k.val;
        new_ent.qk_busy = new_k.pend;
        new_ent.qk      = bus.issue_qk;
        new_ent.imm     = bus.issue_imm;
        new_ent.pc      = bus.issue_pc;
        new_ent.rob     = bus.issue_rob;
    end

    // Entry next state: wakeup, issue-free, dispatch; flush overrides busy.
    always_comb begin
        opnd_t wj, wk;
        busy_d = busy_q;
        ent_d  = ent_q;
        wj     = '0;
        wk     = '0;
        if (rdy) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy_q[i]) begin
                    wj = snoop(ent_q[i].qj_busy, ent_q[i].qj, ent_q[i].vj);
                    wk = snoop(ent_q[i].qk_busy, ent_q[i].qk, ent_q[i].vk);
                    ent_d[i].vj      = wj.val;
                    ent_d[i].qj_busy = wj.pend;
                    ent_d[i].vk      = wk.val;
                    ent_d[i].qk_busy = wk.pend;
                end
            end
            // The selected entry is busy, the free one is not: never the same slot.
            if (sel_valid) begin
                busy_d[sel_idx] = 1'b0;
            end
            if (disp) begin
                ent_d[free_idx]  = new_ent;
                busy_d[free_idx] = 1'b1;
            end
        end
        if (bus.rob_clear) begin
            busy_d = '0;
        end
    end

    // ALU bundle next state: load on issue, otherwise hold data and drop valid.
    always_comb begin
        alu_sgn_d    = 1'b0;
        alu_opcode_d = alu_opcode_q;
        alu_lhs_d    = alu_lhs_q;
        alu_rhs_d    = alu_rhs_q;
        alu_imm_d    = alu_imm_q;
        alu_pc_d     = alu_pc_q;
        alu_rob_d    = alu_rob_q;
        if (rdy && !bus.rob_clear && sel_valid) begin
            alu_sgn_d    = 1'b1;
            alu_opcode_d = ent_q[sel_idx].opcode;
            alu_lhs_d    = ent_q[sel_idx].vj;
            alu_rhs_d    = ent_q[sel_idx].vk;
            alu_imm_d    = ent_q[sel_idx].imm;
            alu_pc_d     = ent_q[sel_idx].pc;
            alu_rob_d    = ent_q[sel_idx].rob;
        end
    end

    // Control state: busy bits and the ALU bundle, cleared by async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q       <= '0;
            alu_sgn_q    <= 1'b0;
            alu_opcode_q <= '0;
            alu_lhs_q    <= '0;
            alu_rhs_q    <= '0;
            alu_imm_q    <= '0;
            alu_pc_q     <= '0;
            alu_rob_q    <= '0;
        end else begin
            busy_q       <= busy_d;
            alu_sgn_q    <= alu_sgn_d;
            alu_opcode_q <= alu_opcode_d;
            alu_lhs_q    <= alu_lhs_d;
            alu_rhs_q    <= alu_rhs_d;
            alu_imm_q    <= alu_imm_d;
            alu_pc_q     <= alu_pc_d;
            alu_rob_q    <= alu_rob_d;
        end
    end

    // Entry payloads are only meaningful while busy, so they carry no reset.
    always_ff @(posedge clk) begin
        ent_q <= ent_d;
    end

    assign bus.rs_full    = rs_full;
    assign bus.alu_sgn    = alu_sgn_q;
    assign bus.alu_opcode = alu_opcode_q;
    assign bus.alu_lhs    = alu_lhs_q;
    assign bus.alu_rhs    = alu_rhs_q;
    assign bus.alu_imm    = alu_imm_q;
    assign bus.alu_pc     = alu_pc_q;
    assign bus.alu_rob    = alu_rob_q;
    assign bus.dbg_busy   = busy_q;

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: dispatch, wakeup, bypass, full,
// flush priority, rdy hold and asynchronous reset.
module tb_reservation_station;
    localparam int RS_SIZE = 8;
    localparam int ROB_W   = 4;
    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_ADDI = 6'd9;

    logic clk;
    logic rst;
    logic rdy;
    int   n_checks;
    int   n_errors;

    reservation_station_if #(.RS_SIZE(RS_SIZE), .ROB_W(ROB_W)) bus ();

    reservation_station #(.RS_SIZE(RS_SIZE), .ROB_W(ROB_W)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.issue_sgn     = 1'b0;
        bus.issue_opcode  = '0;
        bus.issue_vj      = '0;
        bus.issue_vk      = '0;
        bus.issue_imm     = '0;
        bus.issue_pc      = '0;
        bus.issue_qj_busy = 1'b0;
        bus.issue_qk_busy = 1'b0;
        bus.issue_qj      = '0;
        bus.issue_qk      = '0;
        bus.issue_rob     = '0;
        bus.cdb_alu_sgn   = 1'b0;
        bus.cdb_alu_rob   = '0;
        bus.cdb_alu_val   = '0;
        bus.cdb_lsb_sgn   = 1'b0;
        bus.cdb_lsb_rob   = '0;
        bus.cdb_lsb_val   = '0;
        bus.rob_clear     = 1'b0;
    endtask

    task automatic dispatch(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                            input logic qjb, input logic [ROB_W-1:0] qj,
                            input logic qkb, input logic [ROB_W-1:0] qk,
                            input logic [31:0] imm, input logic [31:0] pc,
                            input logic [ROB_W-1:0] rob);
        bus.issue_sgn     = 1'b1;
        bus.issue_opcode  = op;
        bus.issue_vj      = vj;
        bus.issue_vk      = vk;
        bus.issue_qj_busy = qjb;
        bus.issue_qj      = qj;
        bus.issue_qk_busy = qkb;
        bus.issue_qk      = qk;
        bus.issue_imm     = imm;
        bus.issue_pc      = pc;
        bus.issue_rob     = rob;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        rdy = 1'b1;
        idle();

        // Reset state, observed before any clock edge.
        #2;
        chk("reset_alu_sgn", 32'(bus.alu_sgn), 32'd0);
        chk("reset_rs_full", 32'(bus.rs_full), 32'd0);
        chk("reset_busy",    32'(bus.dbg_busy), 32'd0);
        chk("reset_alu_lhs", bus.alu_lhs, 32'd0);
        chk("reset_alu_rob", 32'(bus.alu_rob), 32'd0);
        step();
        step();
        rst = 1'b0;

        // Ready dispatch: issues one edge after dispatch, lands in entry 0.
        dispatch(OP_ADD, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 32'h100, 4'd3);
        step();
        idle();
        chk("ready_disp_busy", 32'(bus.dbg_busy), 32'h01);
        chk("ready_disp_sgn0", 32'(bus.alu_sgn), 32'd0);
        step();
        chk("ready_issue_sgn", 32'(bus.alu_sgn), 32'd1);
        chk("ready_issue_lhs", bus.alu_lhs, 32'd5);
        chk("ready_issue_rhs", bus.alu_rhs, 32'd7);
        chk("ready_issue_rob", 32'(bus.alu_rob), 32'd3);
        chk("ready_issue_op",  32'(bus.alu_opcode), 32'(OP_ADD));
        chk("ready_issue_pc",  bus.alu_pc, 32'h100);
        chk("ready_issue_busy", 32'(bus.dbg_busy), 32'h00);
        step();
        chk("ready_after_sgn", 32'(bus.alu_sgn), 32'd0);
        chk("ready_hold_lhs",  bus.alu_lhs, 32'd5);

        // Wakeup from the LSB CDB.
        dispatch(OP_ADDI, 32'd0, 32'd0, 1'b1, 4'd2, 1'b0, 4'd0, 32'd4, 32'h200, 4'd5);
        step();
        idle();
        chk("wake_disp_busy", 32'(bus.dbg_busy), 32'h01);
        step();
        chk("wake_wait_sgn", 32'(bus.alu_sgn), 32'd0);
        bus.cdb_lsb_sgn = 1'b1;
        bus.cdb_lsb_rob = 4'd2;
        bus.cdb_lsb_val = 32'h10;
        step();
        idle();
        chk("wake_edge_sgn", 32'(bus.alu_sgn), 32'd0);
        step();
        chk("wake_issue_sgn", 32'(bus.alu_sgn), 32'd1);
        chk("wake_issue_lhs", bus.alu_lhs, 32'h10);
        chk("wake_issue_imm", bus.alu_imm, 32'd4);
        chk("wake_issue_rob", 32'(bus.alu_rob), 32'd5);

        // Bypass: pending rk captured from the ALU CDB in the dispatch cycle.
        dispatch(OP_ADD, 32'd1, 32'd0, 1'b0, 4'd0, 1'b1, 4'd6, 32'd0, 32'h300, 4'd7);
        bus.cdb_alu_sgn = 1'b1;
        bus.cdb_alu_rob = 4'd6;
        bus.cdb_alu_val = 32'd9;
        step();
        idle();
        chk("bypass_disp_sgn", 32'(bus.alu_sgn), 32'd0);
        step();
        chk("bypass_issue_sgn", 32'(bus.alu_sgn), 32'd1);
        chk("bypass_issue_rhs", bus.alu_rhs, 32'd9);
        chk("bypass_issue_lhs", bus.alu_lhs, 32'd1);
        chk("bypass_issue_rob", 32'(bus.alu_rob), 32'd7);

        // Full: eight pending entries (waiting on tags 8..15).
        for (int i = 0; i < RS_SIZE; i++) begin
            dispatch(OP_ADD, 32'd0, 32'h70 + 32'(i), 1'b1, 4'(8 + i), 1'b0, 4'd0,
                     32'd0, 32'd0, 4'(i));
            step();
        end
        idle();
        chk("full_rs_full", 32'(bus.rs_full), 32'd1);
        chk("full_busy",    32'(bus.dbg_busy), 32'hFF);
        dispatch(OP_ADD, 32'hDEAD, 32'hBEEF, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 32'd0, 4'd15);
        step();
        idle();
        chk("full_drop_busy", 32'(bus.dbg_busy), 32'hFF);
        step();
        chk("full_drop_sgn", 32'(bus.alu_sgn), 32'd0);
        bus.cdb_alu_sgn = 1'b1;
        bus.cdb_alu_rob = 4'd11;
        bus.cdb_alu_val = 32'h33;
        step();
        idle();
        chk("full_wake_sgn0",  32'(bus.alu_sgn), 32'd0);
        chk("full_wake_full",  32'(bus.rs_full), 32'd1);
        step();
        chk("full_issue_sgn",  32'(bus.alu_sgn), 32'd1);
        chk("full_issue_lhs",  bus.alu_lhs, 32'h33);
        chk("full_issue_rhs",  bus.alu_rhs, 32'h73);
        chk("full_issue_rob",  32'(bus.alu_rob), 32'd3);
        chk("full_issue_busy", 32'(bus.dbg_busy), 32'hF7);
        chk("full_released",   32'(bus.rs_full), 32'd0);
        // Refill the freed slot: must land in entry 3 and issue next.
        dispatch(OP_ADD, 32'h44, 32'h45, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 32'd0, 4'd14);
        step();
        idle();
        chk("refill_busy", 32'(bus.dbg_busy), 32'hFF);
        step();
        chk("refill_issue_rob", 32'(bus.alu_rob), 32'd14);
        chk("refill_issue_lhs", bus.alu_lhs, 32'h44);
        chk("refill_issue_busy", 32'(bus.dbg_busy), 32'hF7);

        // Flush alone, then flush with a concurrent ready dispatch.
        bus.rob_clear = 1'b1;
        step();
        idle();
        chk("flush1_busy", 32'(bus.dbg_busy), 32'h00);
        chk("flush1_sgn",  32'(bus.alu_sgn), 32'd0);
        for (int i = 0; i < 3; i++) begin
            dispatch(OP_ADD, 32'd0, 32'd0, 1'b1, 4'(12 + i), 1'b0, 4'd0, 32'd0, 32'd0, 4'(i));
            step();
        end
        idle();
        chk("flush2_pre_busy", 32'(bus.dbg_busy), 32'h07);
        dispatch(OP_ADD, 32'h55, 32'h56, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 32'd0, 4'd9);
        bus.rob_clear = 1'b1;
        step();
        idle();
        chk("flush2_busy", 32'(bus.dbg_busy), 32'h00);
        chk("flush2_sgn",  32'(bus.alu_sgn), 32'd0);
        step();
        chk("flush2_no_issue", 32'(bus.alu_sgn), 32'd0);

        // rdy low holds the station; entry survives and issues once rdy returns.
        dispatch(OP_ADD, 32'hA, 32'hB, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 32'd0, 4'd1);
        step();
        idle();
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rdy_hold_sgn",  32'(bus.alu_sgn), 32'd0);
            chk("rdy_hold_busy", 32'(bus.dbg_busy), 32'h01);
        end
        rdy = 1'b1;
        step();
        chk("rdy_resume_sgn", 32'(bus.alu_sgn), 32'd1);
        chk("rdy_resume_lhs", bus.alu_lhs, 32'hA);
        chk("rdy_resume_rob", 32'(bus.alu_rob), 32'd1);

        // Freed entry not reused in the same edge; then async reset mid-issue.
        dispatch(OP_ADD, 32'h66, 32'h67, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 32'd0, 4'd6);
        step();
        dispatch(OP_ADD, 32'd0, 32'd0, 1'b1, 4'd15, 1'b0, 4'd0, 32'd0, 32'd0, 4'd5);
        step();
        idle();
        chk("reuse_issue_sgn", 32'(bus.alu_sgn), 32'd1);
        chk("reuse_busy",      32'(bus.dbg_busy), 32'h02);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_sgn",  32'(bus.alu_sgn), 32'd0);
        chk("async_rst_busy", 32'(bus.dbg_busy), 32'h00);
        chk("async_rst_lhs",  bus.alu_lhs, 32'd0);
        chk("async_rst_full", 32'(bus.rs_full), 32'd0);
        step();
        rst = 1'b0;
        dispatch(OP_ADD, 32'h77, 32'h78, 1'b1, 4'd4, 1'b0, 4'd0, 32'd0, 32'd0, 4'd4);
        step();
        idle();
        chk("post_rst_entry0", 32'(bus.dbg_busy), 32'h01);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
